fp8_align_stage: RTL and testbench
==================================

# fp8_align_stage

Pipelined operand-preparation stage for the FP8 (E4M3) adder/accumulator datapath. It unpacks two FP8 operands, orders them by magnitude, computes the exponent difference and effective operation, and classifies special cases. It registers these fields for the far-path (and near-path) add stage directly downstream. The stage uses a valid/ready handshake, a 2-stage pipeline and full-throughput backpressure.

## Interface
Parameters:
- `BIAS`, 7: exponent bias, informational; no arithmetic depends on it.

Ports:
- `clk`  in  1  single clock; all flops rise-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  stage can accept this cycle.
- `op_a`, `op_b`  in  8 each  FP8 `{sign, exp[3:0], man[2:0]}`.
- `op_sub`  in  1  1 = compute a − b, 0 = a + b.
- `out_valid`  out  1  result fields valid.
- `out_ready`  in  1  downstream accepts.
- `fraca_c`, `fracb_c`  out  4 each  `{hidden, man}` of larger / smaller magnitude operand.
- `exp_large`  out  4  effective exponent of larger operand.
- `d`  out  4  `exp_large − exp_small`, range 0..14.
- `sub`  out  1  effective subtraction.
- `sign_res`  out  1  result sign.
- `path_near`  out  1  `sub & (d <= 1)`.
- `exact_cancel`  out  1  `sub` with equal magnitudes.
- `special`  out  1  either operand has exp = 15 (NaN class).

## Operation
- Unpack: exp = 0 → hidden = 0, effective exp = 1 (subnormal). Otherwise hidden = 1, effective exp = exp.
- Magnitude order: compare `{eff_exp, hidden, man}`. The larger one becomes the "a" side. On a tie, op_a stays on the a side.
- `sub = sign_a ^ sign_b ^ op_sub`.
- `sign_res`:
  - `sign_a` if op_a is the larger operand.
  - Otherwise `sign_b ^ op_sub`.
  - If `exact_cancel`, then 0 (+0).
- `d` is the unsigned difference of effective exponents. It is not clamped; the downstream shifter owns saturation.
- `special = (exp_a == 15) | (exp_b == 15)`. All other fields are still computed, and downstream ignores them when `special` is set.
- Stage 1 registers:
  - unpacked fields
  - raw exponent difference in both directions (5-bit subtracts)
  - magnitude-compare result
- Stage 2 registers:
  - the swap mux selected by the compare
  - all outputs

## Timing
- Latency: 2 cycles from an accepted input (`in_valid & in_ready`) to `out_valid`. Throughput is 1 per cycle.
- Stall rule, per stage: stage k loads when `!valid_k | advance_{k+1}`. `advance_2 = out_ready`.
- `in_ready = !valid_1 | !valid_2 | out_ready`, combinational from `out_ready`. There is no skid buffer.
- Holding: while `out_valid & !out_ready`, all outputs hold stable. Stage 1 fills and then holds, so at most 2 transactions are in flight.
- Simultaneous drain and accept in the same cycle is legal and keeps full rate.
- Reset (`rst_n` low at any time, including mid-transfer):
  - `valid_1`, `valid_2` clear immediately.
  - All data outputs go to 0.
  - In-flight transactions are discarded.
  - `in_ready` = 1 from the first cycle after release.
- Data flops have reset values so that outputs are 0 whenever `out_valid` = 0 after reset. Downstream must not rely on data while `out_valid` is low.

## Structure
- Shared package `fp8_pkg`:
  - E4M3 field widths (`EXP_W` = 4, `MAN_W` = 3, `FRAC_W` = 4)
  - `EXP_SPECIAL` = 4'hF
  - `fp8_t` packed struct `{sign, exp, man}`
  - `unpacked_t` `{sign, eff_exp, frac}`
- Sub-module `fp8_unpack`: combinational, one instance per operand. It produces the `unpacked_t` fields and an `is_special` flag.
- Pipeline control (valid bits, load enables) lives in the top module.

## Test plan
- Add: `op_a`=0x38 (1.0), `op_b`=0x40 (2.0), `op_sub`=0 → exactly 2 cycles later:
  - operands swapped: `fraca_c`=8, `fracb_c`=8
  - `exp_large`=8, `d`=1
  - `sub`=0, `sign_res`=0, `path_near`=0
- Near-path subtraction: `op_a`=0x40, `op_b`=0xB8, `op_sub`=0 →
  - `sub`=1, `d`=1, `path_near`=1
  - `sign_res`=0, `exact_cancel`=0
- Exact cancel: `op_a`=0x3C, `op_b`=0x3C, `op_sub`=1 →
  - `exact_cancel`=1, `sign_res`=0
  - `d`=0, `path_near`=1
- Subnormal and special:
  - `op_a`=0x01, `op_b`=0x08 → `fraca_c`=8, `fracb_c`=1, `exp_large`=1, `d`=0.
  - `op_a`=0x7F → `special`=1.
- Backpressure: `out_ready`=0, push 3 back-to-back pairs →
  - `in_ready` drops after 2 accepts, and outputs stay stable.
  - Releasing `out_ready` delivers the 3 results in order on consecutive cycles.
- Reset mid-flight: assert `rst_n`=0 with 2 transactions in flight →
  - `out_valid`=0 and outputs 0 at once.
  - After release, no stale result appears, and `in_ready`=1.

Source files
------------

// File: rtl/fp8_pkg.sv
// Shared FP8 (E4M3) definitions for the adder/accumulator datapath.
//   fp8_t        : packed {sign, exp, man} as it arrives on the operand buses
//   unpacked_t   : {sign, eff_exp, frac} with the hidden bit made explicit
//   align_out_t  : registered result fields of fp8_align_stage
package fp8_pkg;

  localparam int unsigned EXP_W  = 4;
  localparam int unsigned MAN_W  = 3;
  localparam int unsigned FRAC_W = MAN_W + 1;

  localparam logic [EXP_W-1:0] EXP_SPECIAL = 4'hF;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp8_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  eff_exp;
    logic [FRAC_W-1:0] frac;
  } unpacked_t;

  typedef struct packed {
    logic [FRAC_W-1:0] fraca;
    logic [FRAC_W-1:0] fracb;
    logic [EXP_W-1:0]  exp_large;
    logic [EXP_W-1:0]  d;
    logic              sub;
    logic              sign_res;
    logic              path_near;
    logic              exact_cancel;
    logic              special;
  } align_out_t;

  // Magnitude key: effective exponent concatenated with {hidden, man} orders
  // normals and subnormals correctly as an unsigned compare.
  function automatic logic [EXP_W+FRAC_W-1:0] mag_key(unpacked_t u);
    return {u.eff_exp, u.frac};
  endfunction

endpackage

// File: rtl/fp8_unpack.sv
// Combinational E4M3 unpack.
//   op_i         : raw FP8 operand
//   unp_o        : sign, effective exponent (subnormals use 1), {hidden, man}
//   is_special_o : exponent field is all ones (NaN class)
module fp8_unpack
  import fp8_pkg::*;
(
  input  fp8_t      op_i,
  output unpacked_t unp_o,
  output logic      is_special_o
);

  always_comb begin
    unp_o.sign = op_i.sign;
    if (op_i.exp == '0) begin
      unp_o.eff_exp = 4'd1;
      unp_o.frac    = {1'b0, op_i.man};
    end else begin
      unp_o.eff_exp = op_i.exp;
      unp_o.frac    = {1'b1, op_i.man};
    end
    is_special_o = (op_i.exp == EXP_SPECIAL);
  end

endmodule

// File: rtl/fp8_align_stage.sv
// FP8 operand-preparation stage, 2-deep valid/ready pipeline.
// Stage 1 registers unpacked operands, both exponent differences and the
// magnitude compare; stage 2 registers the swap mux and all result fields.
//   clk, rst_n              : clock, asynchronous active-low reset
//   in_valid_i/in_ready_o   : operand handshake (in_ready combinational
//                             from out_ready_i, no skid buffer)
//   op_a_i, op_b_i, op_sub_i: operands, 1 = a - b
//   out_valid_o/out_ready_i : result handshake
//   fraca_c_o .. special_o  : aligned result fields (0 while out_valid_o = 0)
module fp8_align_stage
  import fp8_pkg::*;
#(
  parameter int unsigned BIAS = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [7:0]        op_a_i,
  input  logic [7:0]        op_b_i,
  input  logic              op_sub_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [FRAC_W-1:0] fraca_c_o,
  output logic [FRAC_W-1:0] fracb_c_o,
  output logic [EXP_W-1:0]  exp_large_o,
  output logic [EXP_W-1:0]  d_o,
  output logic              sub_o,
  output logic              sign_res_o,
  output logic              path_near_o,
  output logic              exact_cancel_o,
  output logic              special_o
);

  // ---------------------------------------------------------------------------
  // Pipeline control
  // ---------------------------------------------------------------------------
  logic valid1_q, valid2_q;
  logic load1, load2;

  assign load2      = !valid2_q || out_ready_i;
  assign load1      = !valid1_q || load2;
  assign in_ready_o = load1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
    end else begin
      if (load1) valid1_q <= in_valid_i;
      if (load2) valid2_q <= valid1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: unpack, difference both ways, compare
  // ---------------------------------------------------------------------------
  unpacked_t unp_a, unp_b;
  logic      spec_a, spec_b;

  fp8_unpack u_unpack_a (
    .op_i        (fp8_t'(op_a_i)),
    .unp_o       (unp_a),
    .is_special_o(spec_a)
  );

  fp8_unpack u_unpack_b (
    .op_i        (fp8_t'(op_b_i)),
    .unp_o       (unp_b),
    .is_special_o(spec_b)
  );

  logic [EXP_W:0] diff_ab_d, diff_ba_d;
  logic           a_ge_b_d, mag_eq_d;

  always_comb begin
    diff_ab_d = {1'b0, unp_a.eff_exp} - {1'b0, unp_b.eff_exp};
    diff_ba_d = {1'b0, unp_b.eff_exp} - {1'b0, unp_a.eff_exp};
    // Ties keep op_a on the large side.
    a_ge_b_d  = mag_key(unp_a) >= mag_key(unp_b);
    mag_eq_d  = mag_key(unp_a) == mag_key(unp_b);
  end

  unpacked_t      unp_a_q, unp_b_q;
  logic [EXP_W:0] diff_ab_q, diff_ba_q;
  logic           a_ge_b_q, mag_eq_q, sub_q, sign_b_eff_q, special_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unp_a_q      <= '0;
      unp_b_q      <= '0;
      diff_ab_q    <= '0;
      diff_ba_q    <= '0;
      a_ge_b_q     <= 1'b0;
      mag_eq_q     <= 1'b0;
      sub_q        <= 1'b0;
      sign_b_eff_q <= 1'b0;
      special_q    <= 1'b0;
    end else if (load1 && in_valid_i) begin
      unp_a_q      <= unp_a;
      unp_b_q      <= unp_b;
      diff_ab_q    <= diff_ab_d;
      diff_ba_q    <= diff_ba_d;
      a_ge_b_q     <= a_ge_b_d;
      mag_eq_q     <= mag_eq_d;
      sub_q        <= unp_a.sign ^ unp_b.sign ^ op_sub_i;
      sign_b_eff_q <= unp_b.sign ^ op_sub_i;
      special_q    <= spec_a | spec_b;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: swap mux and result fields
  // ---------------------------------------------------------------------------
  align_out_t res_d, res_q;

  always_comb begin
    res_d = '0;
    if (a_ge_b_q) begin
      res_d.fraca     = unp_a_q.frac;
      res_d.fracb     = unp_b_q.frac;
      res_d.exp_large = unp_a_q.eff_exp;
      res_d.d         = diff_ab_q[EXP_W-1:0];
      res_d.sign_res  = unp_a_q.sign;
    end else begin
      res_d.fraca     = unp_b_q.frac;
      res_d.fracb     = unp_a_q.frac;
      res_d.exp_large = unp_b_q.eff_exp;
      res_d.d         = diff_ba_q[EXP_W-1:0];
      res_d.sign_res  = sign_b_eff_q;
    end
    res_d.sub          = sub_q;
    res_d.exact_cancel = sub_q & mag_eq_q;
    res_d.path_near    = sub_q & (res_d.d <= 4'd1);
    res_d.special      = special_q;
    // Exact cancellation always yields +0.
    if (res_d.exact_cancel) res_d.sign_res = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
    end else if (load2) begin
      // Bubbles load zeros so the outputs read 0 whenever out_valid_o is low.
      res_q <= valid1_q ? res_d : '0;
    end
  end

  assign out_valid_o    = valid2_q;
  assign fraca_c_o      = res_q.fraca;
  assign fracb_c_o      = res_q.fracb;
  assign exp_large_o    = res_q.exp_large;
  assign d_o            = res_q.d;
  assign sub_o          = res_q.sub;
  assign sign_res_o     = res_q.sign_res;
  assign path_near_o    = res_q.path_near;
  assign exact_cancel_o = res_q.exact_cancel;
  assign special_o      = res_q.special;

  // BIAS is informational; the sign bit of each difference is implied by the
  // registered compare, so it is never read.
  logic unused_bits;
  assign unused_bits = ^{BIAS, diff_ab_q[EXP_W], diff_ba_q[EXP_W]};

endmodule

// File: tb/tb_fp8_align_stage.sv
module tb_fp8_align_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, op_sub, out_valid, out_ready;
  logic [7:0] op_a, op_b;
  logic [3:0] fraca, fracb, exp_large, d;
  logic       sub, sign_res, path_near, exact_cancel, special;

  always #5 clk = ~clk;

  fp8_align_stage #(.BIAS(7)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .op_a_i        (op_a),
    .op_b_i        (op_b),
    .op_sub_i      (op_sub),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .fraca_c_o     (fraca),
    .fracb_c_o     (fracb),
    .exp_large_o   (exp_large),
    .d_o           (d),
    .sub_o         (sub),
    .sign_res_o    (sign_res),
    .path_near_o   (path_near),
    .exact_cancel_o(exact_cancel),
    .special_o     (special)
  );

  // Expected result packed as {fraca, fracb, exp_large, d, sub, sign, near, exact, special}
  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [20:0] exp_out;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  vec_t vecs[13];

  function automatic logic [20:0] mk(input int fa, input int fb, input int el, input int dd,
                                     input bit sb, input bit sg, input bit nr, input bit ec,
                                     input bit sp);
    return {fa[3:0], fb[3:0], el[3:0], dd[3:0], sb, sg, nr, ec, sp};
  endfunction

  function automatic logic [20:0] act_out();
    return {fraca, fracb, exp_large, d, sub, sign_res, path_near, exact_cancel, special};
  endfunction

  task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    op_a   = v.a;
    op_b   = v.b;
    op_sub = v.s;
  endtask

  initial begin
    //            fa  fb  el  d  sub sg nr ec sp
    vecs[0]  = '{8'h38, 8'h40, 1'b0, mk( 8,  8,  8,  1, 0, 0, 0, 0, 0)};
    vecs[1]  = '{8'h40, 8'hB8, 1'b0, mk( 8,  8,  8,  1, 1, 0, 1, 0, 0)};
    vecs[2]  = '{8'h3C, 8'h3C, 1'b1, mk(12, 12,  7,  0, 1, 0, 1, 1, 0)};
    vecs[3]  = '{8'h01, 8'h08, 1'b0, mk( 8,  1,  1,  0, 0, 0, 0, 0, 0)};
    vecs[4]  = '{8'h7F, 8'h38, 1'b0, mk(15,  8, 15,  8, 0, 0, 0, 0, 1)};
    vecs[5]  = '{8'h38, 8'h40, 1'b1, mk( 8,  8,  8,  1, 1, 1, 1, 0, 0)};
    vecs[6]  = '{8'hC8, 8'h10, 1'b0, mk( 8,  8,  9,  7, 1, 1, 0, 0, 0)};
    vecs[7]  = '{8'h38, 8'hB8, 1'b0, mk( 8,  8,  7,  0, 1, 0, 1, 1, 0)};
    vecs[8]  = '{8'hB8, 8'hB8, 1'b0, mk( 8,  8,  7,  0, 0, 1, 0, 0, 0)};
    vecs[9]  = '{8'h00, 8'h70, 1'b0, mk( 8,  0, 14, 13, 0, 0, 0, 0, 0)};
    vecs[10] = '{8'h78, 8'h01, 1'b0, mk( 8,  1, 15, 14, 0, 0, 0, 0, 1)};
    vecs[11] = '{8'h02, 8'h05, 1'b1, mk( 5,  2,  1,  0, 1, 1, 1, 0, 0)};
    vecs[12] = '{8'h30, 8'hF9, 1'b0, mk( 9,  8, 15,  9, 1, 1, 0, 0, 1)};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op_a = '0; op_b = '0; op_sub = 1'b0;
    repeat (2) @(negedge clk);
    check1("reset_out_valid", out_valid, 1'b0);
    check("reset_outputs", act_out(), '0);
    rst_n = 1'b1;
    @(negedge clk);
    check1("reset_in_ready", in_ready, 1'b1);

    // Single transactions: exact 2-cycle latency
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i]);
      in_valid = 1'b1;
      check1($sformatf("v%0d_in_ready", i), in_ready, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      check1($sformatf("v%0d_early_valid", i), out_valid, 1'b0);
      @(negedge clk);
      check1($sformatf("v%0d_out_valid", i), out_valid, 1'b1);
      check($sformatf("v%0d_fields", i), act_out(), vecs[i].exp_out);
      @(negedge clk);
      check1($sformatf("v%0d_drained", i), out_valid, 1'b0);
      check($sformatf("v%0d_idle_zero", i), act_out(), '0);
    end

    // Backpressure: three back-to-back pairs against a stalled sink
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(vecs[i]);
      in_valid = 1'b1;
      check1($sformatf("bp_accept%0d", i), in_ready, 1'b1);
      @(negedge clk);
    end
    drive(vecs[2]);
    for (int k = 0; k < 3; k++) begin
      check1($sformatf("bp_stall_ready%0d", k), in_ready, 1'b0);
      check1($sformatf("bp_hold_valid%0d", k), out_valid, 1'b1);
      check($sformatf("bp_hold%0d", k), act_out(), vecs[0].exp_out);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check1("bp_ready_comb", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 1; i < 3; i++) begin
      check1($sformatf("bp_out_valid%0d", i), out_valid, 1'b1);
      check($sformatf("bp_order%0d", i), act_out(), vecs[i].exp_out);
      @(negedge clk);
    end
    check1("bp_drained", out_valid, 1'b0);

    // Simultaneous drain and accept at full rate
    for (int i = 0; i < 5; i++) begin
      drive(vecs[i]);
      in_valid = 1'b1;
      if (i >= 2) check($sformatf("stream%0d", i - 2), act_out(), vecs[i-2].exp_out);
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int i = 3; i < 5; i++) begin
      check($sformatf("stream%0d", i), act_out(), vecs[i].exp_out);
      @(negedge clk);
    end

    // Reset with two transactions in flight
    out_ready = 1'b0;
    for (int i = 5; i < 7; i++) begin
      drive(vecs[i]);
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check1("rst_pre_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check1("rst_async_valid", out_valid, 1'b0);
    check("rst_async_zero", act_out(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check1("rst_in_ready", in_ready, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check1($sformatf("rst_no_stale%0d", k), out_valid, 1'b0);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
